// File: rtl/dsp_post_adder.sv
// Post-multiplier adder of the DSP slice: sums the two partial products into M and combines
// M, C and the P feedback in a 48-bit add/subtract ALU. The C, control and P registers are optional.
module dsp_post_adder #(
    parameter int unsigned PREG     = 1,
    parameter int unsigned CREG     = 1,
    parameter int unsigned CTRLREG  = 1,
    parameter string       USE_MULT = "multiply"
) (
    input  logic        CLK,
    input  logic        RSTP,
    input  logic        RSTC,
    input  logic        RSTCTRL,
    input  logic        CEP,
    input  logic        CEC,
    input  logic        CECTRL,
    input  logic [42:0] PP1,
    input  logic [42:0] PP2,
    input  logic [47:0] C,
    input  logic [3:0]  OPMODE,
    input  logic        SUB,
    input  logic        CARRYIN,
    output logic [47:0] P,
    output logic        OVERFLOW,
    output logic        UNDERFLOW
);

    localparam int unsigned PPW   = 43;
    localparam int unsigned DW    = 48;
    localparam int unsigned AW    = 49;
    localparam int unsigned OPW   = 4;
    localparam int unsigned SHIFT = 17;
    localparam bit          MULT_EN = (USE_MULT != "none");

    logic        [DW-1:0]  c_use;
    logic        [OPW-1:0] opmode_use;
    logic                  sub_use;
    logic                  cin_use;
    logic signed [DW-1:0]  p_fb;
    logic signed [DW-1:0]  m;
    logic signed [DW-1:0]  x_mux;
    logic signed [DW-1:0]  z_mux;
    logic signed [AW-1:0]  z_ext;
    logic signed [AW-1:0]  xc_ext;
    logic signed [AW-1:0]  r;
    logic                  ovf;
    logic                  unf;

    // Operand C register
    if (CREG != 0) begin : g_creg
        logic [DW-1:0] c_q;
        always_ff @(posedge CLK) begin
            if (RSTC) begin
                c_q <= '0;
            end else if (CEC) begin
                c_q <= C;
            end
        end
        assign c_use = c_q;
    end else begin : g_clive
        assign c_use = C;
    end

    // OPMODE/SUB/CARRYIN register
    if (CTRLREG != 0) begin : g_ctrlreg
        logic [OPW-1:0] opmode_q;
        logic           sub_q;
        logic           cin_q;
        always_ff @(posedge CLK) begin
            if (RSTCTRL) begin
                opmode_q <= '0;
                sub_q    <= 1'b0;
                cin_q    <= 1'b0;
            end else if (CECTRL) begin
                opmode_q <= OPMODE;
                sub_q    <= SUB;
                cin_q    <= CARRYIN;
            end
        end
        assign opmode_use = opmode_q;
        assign sub_use    = sub_q;
        assign cin_use    = cin_q;
    end else begin : g_ctrllive
        assign opmode_use = OPMODE;
        assign sub_use    = SUB;
        assign cin_use    = CARRYIN;
    end

    // Product recombination, wrapped to 48 bits
    always_comb begin
        m = '0;
        if (MULT_EN) begin
            m = $signed({{(DW-PPW){PP1[PPW-1]}}, PP1}) + $signed({{(DW-PPW){PP2[PPW-1]}}, PP2});
        end
    end

    // Operand muxes; feedback is zero when P is not registered so there is no comb loop
    always_comb begin
        x_mux = '0;
        z_mux = '0;
        case (opmode_use[1:0])
            2'b01:   x_mux = m;
            2'b10:   x_mux = $signed(c_use);
            default: x_mux = '0;
        endcase
        case (opmode_use[3:2])
            2'b01:   z_mux = p_fb;
            2'b10:   z_mux = $signed(c_use);
            2'b11:   z_mux = p_fb >>> SHIFT;
            default: z_mux = '0;
        endcase
    end

    // 49-bit ALU: one guard bit exposes overflow/underflow before the 48-bit wrap
    always_comb begin
        z_ext  = {z_mux[DW-1], z_mux};
        xc_ext = $signed({x_mux[DW-1], x_mux}) + $signed({{(AW-1){1'b0}}, cin_use});
        r      = sub_use ? (z_ext - xc_ext) : (z_ext + xc_ext);
        ovf    = ~r[AW-1] &  r[DW-1];
        unf    =  r[AW-1] & ~r[DW-1];
    end

    // Result register (or pass-through) with its flags
    if (PREG != 0) begin : g_preg
        logic [DW-1:0] p_q;
        logic          ovf_q;
        logic          unf_q;
        always_ff @(posedge CLK) begin
            if (RSTP) begin
                p_q   <= '0;
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else if (CEP) begin
                p_q   <= r[DW-1:0];
                ovf_q <= ovf;
                unf_q <= unf;
            end
        end
        assign p_fb      = $signed(p_q);
        assign P         = p_q;
        assign OVERFLOW  = ovf_q;
        assign UNDERFLOW = unf_q;
    end else begin : g_plive
        assign p_fb      = '0;
        assign P         = r[DW-1:0];
        assign OVERFLOW  = ovf;
        assign UNDERFLOW = unf;
    end

endmodule

// File: tb/tb_dsp_post_adder.sv
// Directed bench for dsp_post_adder: fully registered instance plus combinational and
// no-multiplier instances sharing the same stimulus.
module tb_dsp_post_adder;

    logic        clk = 1'b0;
    logic        rstp, rstc, rstctrl, cep, cec, cectrl;
    logic [42:0] pp1, pp2;
    logic [47:0] c;
    logic [3:0]  opmode;
    logic        sub, cin;
    logic [47:0] p_reg, p_comb, p_none;
    logic        ovf_reg, unf_reg, ovf_comb, unf_comb, ovf_none, unf_none;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dsp_post_adder u_reg (
        .CLK(clk), .RSTP(rstp), .RSTC(rstc), .RSTCTRL(rstctrl), .CEP(cep), .CEC(cec),
        .CECTRL(cectrl), .PP1(pp1), .PP2(pp2), .C(c), .OPMODE(opmode), .SUB(sub),
        .CARRYIN(cin), .P(p_reg), .OVERFLOW(ovf_reg), .UNDERFLOW(unf_reg)
    );

    dsp_post_adder #(.PREG(0), .CREG(0), .CTRLREG(0)) u_comb (
        .CLK(clk), .RSTP(rstp), .RSTC(rstc), .RSTCTRL(rstctrl), .CEP(cep), .CEC(cec),
        .CECTRL(cectrl), .PP1(pp1), .PP2(pp2), .C(c), .OPMODE(opmode), .SUB(sub),
        .CARRYIN(cin), .P(p_comb), .OVERFLOW(ovf_comb), .UNDERFLOW(unf_comb)
    );

    dsp_post_adder #(.PREG(0), .CREG(0), .CTRLREG(0), .USE_MULT("none")) u_none (
        .CLK(clk), .RSTP(rstp), .RSTC(rstc), .RSTCTRL(rstctrl), .CEP(cep), .CEC(cec),
        .CECTRL(cectrl), .PP1(pp1), .PP2(pp2), .C(c), .OPMODE(opmode), .SUB(sub),
        .CARRYIN(cin), .P(p_none), .OVERFLOW(ovf_none), .UNDERFLOW(unf_none)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstp = 1'b1; rstc = 1'b1; rstctrl = 1'b1;
        cep = 1'b1; cec = 1'b1; cectrl = 1'b1;
        pp1 = '0; pp2 = '0; c = '0; opmode = '0; sub = 1'b0; cin = 1'b0;
        tick();
        vectors++;
        if ({ovf_reg, unf_reg, p_reg} !== {2'b00, 48'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", {ovf_reg, unf_reg, p_reg}, {2'b00, 48'd0});
        end
        rstp = 1'b0; rstc = 1'b0; rstctrl = 1'b0;
    endtask

    task automatic test_product();
        pp1 = 43'd100; pp2 = -43'sd40; opmode = 4'b0001;
        tick();
        vectors++;
        if (p_reg !== 48'd0) begin
            miscompares++;
            $display("FAIL product_ctrl_latency: got %0d expected 0", p_reg);
        end
        vectors++;
        if (p_comb !== 48'd60) begin
            miscompares++;
            $display("FAIL product_comb: got %0d expected 60", p_comb);
        end
        tick();
        vectors++;
        if ({ovf_reg, unf_reg, p_reg} !== {2'b00, 48'd60}) begin
            miscompares++;
            $display("FAIL product_reg: got %h expected %h", {ovf_reg, unf_reg, p_reg}, {2'b00, 48'd60});
        end
    endtask

    task automatic test_accumulate();
        logic [47:0] exp_p;
        opmode = 4'b0101; pp1 = 43'd5; pp2 = '0; cep = 1'b0; rstp = 1'b1;
        tick();
        rstp = 1'b0; cep = 1'b1;
        vectors++;
        if (p_reg !== 48'd0) begin
            miscompares++;
            $display("FAIL accum_start: got %0d expected 0", p_reg);
        end
        vectors++;
        if (p_comb !== 48'd5) begin
            miscompares++;
            $display("FAIL accum_comb_no_feedback: got %0d expected 5", p_comb);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_p = 48'(5 * (i + 1));
            vectors++;
            if ({ovf_reg, unf_reg, p_reg} !== {2'b00, exp_p}) begin
                miscompares++;
                $display("FAIL accum_step%0d: got %0d expected %0d", i, p_reg, exp_p);
            end
        end
        cep = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (p_reg !== 48'd20) begin
                miscompares++;
                $display("FAIL accum_hold%0d: got %0d expected 20", i, p_reg);
            end
        end
        cep = 1'b1;
    endtask

    task automatic test_subtract_c();
        c = 48'd1000; opmode = 4'b1001; pp1 = 43'd300; sub = 1'b1; cin = 1'b1;
        tick();
        vectors++;
        if (p_reg !== 48'd320) begin
            miscompares++;
            $display("FAIL sub_c_latency: got %0d expected 320", p_reg);
        end
        vectors++;
        if (p_comb !== 48'd699) begin
            miscompares++;
            $display("FAIL sub_c_comb: got %0d expected 699", p_comb);
        end
        tick();
        vectors++;
        if (p_reg !== 48'd699) begin
            miscompares++;
            $display("FAIL sub_c_reg: got %0d expected 699", p_reg);
        end
    endtask

    task automatic test_overflow();
        c = 48'h7FFF_FFFF_FFFF; opmode = 4'b1000; sub = 1'b0; cin = 1'b0; pp1 = '0;
        tick();
        tick();
        vectors++;
        if (p_reg !== 48'h7FFF_FFFF_FFFF) begin
            miscompares++;
            $display("FAIL ovf_load: got %h expected 7fffffffffff", p_reg);
        end
        opmode = 4'b0101; pp1 = 43'd1;
        tick();
        tick();
        vectors++;
        if ({ovf_reg, unf_reg, p_reg} !== {2'b10, 48'h8000_0000_0000}) begin
            miscompares++;
            $display("FAIL ovf_wrap: got %h expected %h", {ovf_reg, unf_reg, p_reg}, {2'b10, 48'h8000_0000_0000});
        end
        pp1 = '0;
        tick();
        vectors++;
        if ({ovf_reg, unf_reg, p_reg} !== {2'b00, 48'h8000_0000_0000}) begin
            miscompares++;
            $display("FAIL ovf_clear: got %h expected %h", {ovf_reg, unf_reg, p_reg}, {2'b00, 48'h8000_0000_0000});
        end
        sub = 1'b1;
        tick();
        pp1 = 43'd1;
        tick();
        vectors++;
        if ({ovf_reg, unf_reg, p_reg} !== {2'b01, 48'h7FFF_FFFF_FFFF}) begin
            miscompares++;
            $display("FAIL unf_wrap: got %h expected %h", {ovf_reg, unf_reg, p_reg}, {2'b01, 48'h7FFF_FFFF_FFFF});
        end
    endtask

    task automatic test_shift();
        c = 48'h0000_000C_0000; opmode = 4'b1000; sub = 1'b0; cin = 1'b0; pp1 = '0;
        tick();
        tick();
        vectors++;
        if (p_reg !== 48'h0000_000C_0000) begin
            miscompares++;
            $display("FAIL shift_load_pos: got %h expected 0000000c0000", p_reg);
        end
        opmode = 4'b1100;
        tick();
        tick();
        vectors++;
        if (p_reg !== 48'd6) begin
            miscompares++;
            $display("FAIL shift_pos: got %0d expected 6", p_reg);
        end
        c = 48'hFFFF_FFF0_0000; opmode = 4'b1000;
        tick();
        tick();
        vectors++;
        if (p_reg !== 48'hFFFF_FFF0_0000) begin
            miscompares++;
            $display("FAIL shift_load_neg: got %h expected fffffff00000", p_reg);
        end
        opmode = 4'b1100;
        tick();
        tick();
        vectors++;
        if (p_reg !== 48'hFFFF_FFFF_FFF8) begin
            miscompares++;
            $display("FAIL shift_neg: got %h expected fffffffffff8", p_reg);
        end
    endtask

    task automatic test_ce_hold();
        opmode = 4'b1000; cec = 1'b0; c = 48'd555;
        tick();
        tick();
        vectors++;
        if (p_reg !== 48'hFFFF_FFF0_0000) begin
            miscompares++;
            $display("FAIL cec_hold: got %h expected fffffff00000", p_reg);
        end
        cec = 1'b1;
    endtask

    task automatic test_reset_mid_accum();
        opmode = 4'b0101; pp1 = 43'd7;
        tick();
        tick();
        vectors++;
        if (p_reg !== 48'hFFFF_FFF0_0007) begin
            miscompares++;
            $display("FAIL accum_neg: got %h expected fffffff00007", p_reg);
        end
        rstp = 1'b1;
        tick();
        rstp = 1'b0;
        vectors++;
        if ({ovf_reg, unf_reg, p_reg} !== {2'b00, 48'd0}) begin
            miscompares++;
            $display("FAIL rstp_over_cep: got %h expected %h", {ovf_reg, unf_reg, p_reg}, {2'b00, 48'd0});
        end
        tick();
        vectors++;
        if (p_reg !== 48'd7) begin
            miscompares++;
            $display("FAIL accum_resume: got %0d expected 7", p_reg);
        end
        rstctrl = 1'b1;
        tick();
        rstctrl = 1'b0;
        vectors++;
        if (p_reg !== 48'd14) begin
            miscompares++;
            $display("FAIL rstctrl_edge: got %0d expected 14", p_reg);
        end
        tick();
        vectors++;
        if (p_reg !== 48'd0) begin
            miscompares++;
            $display("FAIL rstctrl_cleared_opmode: got %0d expected 0", p_reg);
        end
    endtask

    task automatic test_no_mult();
        opmode = 4'b0001; pp1 = 43'd7; pp2 = '0; sub = 1'b0; cin = 1'b0;
        #1;
        vectors++;
        if (p_comb !== 48'd7) begin
            miscompares++;
            $display("FAIL mult_comb: got %0d expected 7", p_comb);
        end
        vectors++;
        if (p_none !== 48'd0) begin
            miscompares++;
            $display("FAIL no_mult_zero: got %0d expected 0", p_none);
        end
        opmode = 4'b1000; c = 48'd555;
        #1;
        vectors++;
        if (p_none !== 48'd555) begin
            miscompares++;
            $display("FAIL no_mult_c_path: got %0d expected 555", p_none);
        end
    endtask

    initial begin
        test_reset();
        test_product();
        test_accumulate();
        test_subtract_c();
        test_overflow();
        test_shift();
        test_ce_hold();
        test_reset_mid_accum();
        test_no_mult();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
